// File: rtl/pokemon_pkg.sv
// Shared definitions for the sprite/background fetch path.
//   MAP_W/MAP_H     : background map size in map pixels
//   SPR_DIM         : sprite edge length in sprite pixels
//   SCALE_SHIFT     : map/sprite to screen scale (log2)
//   screen_state_t  : which screen is being shown
//   fetch_stage_t   : per-pixel side-band carried down the fetch pipeline
//   map_linear_addr : screen coordinate -> linear map/menu RAM address
package pokemon_pkg;

    localparam int unsigned MAP_W       = 320;
    localparam int unsigned MAP_H       = 240;
    localparam int unsigned SPR_DIM     = 16;
    localparam int unsigned SCALE_SHIFT = 1;

    // Visible screen size and on-screen sprite footprint after scaling.
    localparam int unsigned SCREEN_W   = MAP_W << SCALE_SHIFT;
    localparam int unsigned SCREEN_H   = MAP_H << SCALE_SHIFT;
    localparam int unsigned SPR_SCREEN = SPR_DIM << SCALE_SHIFT;

    typedef enum logic [1:0] {
        MENU,
        ARMED,
        MAP
    } screen_state_t;

    typedef struct packed {
        logic valid;
        logic hit;
        logic mode;  // 1 = pixel belongs to the map screen
    } fetch_stage_t;

    // sy*320 + sx, written as shifts so no multiplier is needed.
    function automatic logic [18:0] map_linear_addr(input logic [9:0] draw_x,
                                                    input logic [9:0] draw_y);
        logic [18:0] sx;
        logic [18:0] sy;
        sx = 19'(draw_x >> SCALE_SHIFT);
        sy = 19'(draw_y >> SCALE_SHIFT);
        return (sy << 8) + (sy << 6) + sx;
    endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational sprite hit test and character-RAM address generation for one
// 16x16 sprite drawn at 2x scale.
//   en_i        : pixel is visible and in range; a disabled pixel never hits
//   draw_x_i/y  : screen coordinate being drawn
//   spr_x_i/y   : sprite top-left on screen
//   spr_frame_i : sprite frame (already clamped to the stored frame count)
//   hit_o       : pixel lies inside the sprite footprint
//   char_addr_o : frame*256 + row*16 + col on a hit, 0 otherwise
module sprite_hit_calc
    import pokemon_pkg::*;
(
    input  logic        en_i,
    input  logic [9:0]  draw_x_i,
    input  logic [9:0]  draw_y_i,
    input  logic [9:0]  spr_x_i,
    input  logic [9:0]  spr_y_i,
    input  logic [4:0]  spr_frame_i,
    output logic        hit_o,
    output logic [12:0] char_addr_o
);

    // 11-bit signed offsets: a sprite partly off the left/top edge gives a
    // negative offset, which must be a miss rather than wrapping around.
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               in_x;
    logic               in_y;

    always_comb begin
        dx = $signed({1'b0, draw_x_i}) - $signed({1'b0, spr_x_i});
        dy = $signed({1'b0, draw_y_i}) - $signed({1'b0, spr_y_i});

        in_x = ~dx[10] && (dx[9:0] < 10'(SPR_SCREEN));
        in_y = ~dy[10] && (dy[9:0] < 10'(SPR_SCREEN));

        hit_o       = en_i && in_x && in_y;
        char_addr_o = '0;
        if (hit_o) begin
            // 256-byte frames of 16 rows x 16 columns; offsets halved for 2x scale.
            char_addr_o = {spr_frame_i, dy[4:1], dx[4:1]};
        end
    end

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Per-pixel read scheduler for the character, map and start-menu RAMs.
// Tracks the displayed screen (changes only on frame boundaries), issues one
// read address per RAM per visible pixel, and composites the sprite over the
// map three cycles later.
//   Clk, Reset_n          : clock, synchronous active-low reset
//   frame_start           : one-cycle pulse at start of vertical blank
//   pix_active, DrawX/Y   : pixel being drawn this cycle
//   start_press           : request to leave the menu
//   char_x/y, char_frame  : sprite position/frame, latched on frame_start
//   map/menu/char_addr    : registered RAM read addresses
//   map/menu/char_data    : RAM read data, one cycle after the address
//   pixel_index/valid     : composited palette index and its strobe
//   in_map                : 1 while the map screen is shown
module pixel_fetch_ctrl
    import pokemon_pkg::*;
#(
    parameter logic [7:0]  TRANSPARENT = 8'h00,
    parameter int unsigned CHAR_FRAMES = 25
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        pix_active,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        start_press,
    input  logic [9:0]  char_x,
    input  logic [9:0]  char_y,
    input  logic [4:0]  char_frame,
    output logic [18:0] map_addr,
    output logic [18:0] menu_addr,
    output logic [12:0] char_addr,
    input  logic [7:0]  map_data,
    input  logic [7:0]  menu_data,
    input  logic [7:0]  char_data,
    output logic [7:0]  pixel_index,
    output logic        pixel_valid,
    output logic        in_map
);

    localparam logic [4:0] LastFrame = 5'(CHAR_FRAMES - 1);

    // Screen mode FSM
    screen_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MENU:    if (start_press) state_d = ARMED;
            ARMED:   if (frame_start) state_d = MAP;
            MAP:     state_d = MAP;
            default: state_d = MENU;
        endcase
    end

    assign in_map = (state_q == MAP);

    // Frame shadow registers
    logic [9:0] char_x_q, char_x_d;
    logic [9:0] char_y_q, char_y_d;
    logic [4:0] char_frame_q, char_frame_d;

    always_comb begin
        char_x_d     = char_x_q;
        char_y_d     = char_y_q;
        char_frame_d = char_frame_q;
        if (frame_start) begin
            char_x_d     = char_x;
            char_y_d     = char_y;
            char_frame_d = (32'(char_frame) >= CHAR_FRAMES) ? LastFrame : char_frame;
        end
    end

    // Stage 0: address generation
    logic        pix_ok;
    logic        spr_hit;
    logic [12:0] spr_addr;

    assign pix_ok = pix_active && (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));

    sprite_hit_calc u_sprite_hit_calc (
        .en_i        (pix_ok),
        .draw_x_i    (DrawX),
        .draw_y_i    (DrawY),
        .spr_x_i     (char_x_q),
        .spr_y_i     (char_y_q),
        .spr_frame_i (char_frame_q),
        .hit_o       (spr_hit),
        .char_addr_o (spr_addr)
    );

    fetch_stage_t s0_q, s0_d;
    logic [18:0]  map_addr_q, map_addr_d;
    logic [12:0]  char_addr_q, char_addr_d;

    always_comb begin
        s0_d        = '0;
        map_addr_d  = '0;
        char_addr_d = '0;
        if (pix_ok) begin
            s0_d.valid  = 1'b1;
            s0_d.hit    = spr_hit;
            // Mode is captured per pixel so a screen switch never affects
            // pixels already in flight.
            s0_d.mode   = (state_q == MAP);
            map_addr_d  = map_linear_addr(DrawX, DrawY);
            char_addr_d = spr_addr;
        end
    end

    // Map and menu RAMs share the same geometry, hence the same address.
    assign map_addr  = map_addr_q;
    assign menu_addr = map_addr_q;
    assign char_addr = char_addr_q;

    // Stage 1: RAM read in progress
    fetch_stage_t s1_q, s1_d;

    assign s1_d = s0_q;

    // Stage 2: compositing
    logic [7:0] pixel_index_q, pixel_index_d;
    logic       pixel_valid_q, pixel_valid_d;

    always_comb begin
        pixel_index_d = '0;
        pixel_valid_d = s1_q.valid;
        if (s1_q.valid) begin
            if (!s1_q.mode) begin
                pixel_index_d = menu_data;
            end else if (s1_q.hit && (char_data != TRANSPARENT)) begin
                pixel_index_d = char_data;
            end else begin
                pixel_index_d = map_data;
            end
        end
    end

    assign pixel_index = pixel_index_q;
    assign pixel_valid = pixel_valid_q;

    // State registers; in-flight pixels are dropped on reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= MENU;
            char_x_q      <= '0;
            char_y_q      <= '0;
            char_frame_q  <= '0;
            s0_q          <= '0;
            map_addr_q    <= '0;
            char_addr_q   <= '0;
            s1_q          <= '0;
            pixel_index_q <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            char_x_q      <= char_x_d;
            char_y_q      <= char_y_d;
            char_frame_q  <= char_frame_d;
            s0_q          <= s0_d;
            map_addr_q    <= map_addr_d;
            char_addr_q   <= char_addr_d;
            s1_q          <= s1_d;
            pixel_index_q <= pixel_index_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

endmodule

// File: doc/pixel_fetch_ctrl.md
# pixel_fetch_ctrl

Per-pixel read scheduler for the three sprite/background RAMs (character, map, start-menu) that sit between game logic and the VGA output. Each active pixel gets one read address per RAM in a fixed 3-cycle pipeline. The block tracks which screen is shown, switching only on frame boundaries, and composites the 16x16 character sprite over the 320x240 map at 2x scale. It outputs an 8-bit palette index, aligned to a valid strobe, to the palette/colour mapper.

## Interface
Parameters:
- TRANSPARENT, 8'h00: character palette index treated as see-through
- CHAR_FRAMES, 25: number of 256-byte sprite frames stored in character RAM

Ports:
- Clk  in  1  system/pixel clock
- Reset_n  in  1  synchronous, active-low reset, sampled on rising Clk
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pix_active  in  1  DrawX/DrawY refer to a visible pixel this cycle
- DrawX, DrawY  in  10 each  screen coordinate (640x480 space)
- start_press  in  1  level; request to leave the menu
- char_x, char_y  in  10 each  sprite top-left on screen; sampled at frame_start
- char_frame  in  5  sprite frame index; sampled at frame_start
- map_addr, menu_addr  out  19 each  read addresses to map/menu RAM
- char_addr  out  13  read address to character RAM
- map_data, menu_data, char_data  in  8 each  RAM read data (1-cycle RAM latency)
- pixel_index  out  8  composited palette index
- pixel_valid  out  1  pixel_index is valid this cycle
- in_map  out  1  current screen: 0 = menu, 1 = map

## Operation
- Mode FSM, states MENU, ARMED, MAP; reset state is MENU.
  - MENU -> ARMED when start_press = 1.
  - ARMED -> MAP on the next frame_start.
  - MAP is terminal until reset.
  - in_map = (state == MAP).
  - The screen never changes mid-frame.
- The frame shadow registers (char_x, char_y, char_frame) load on frame_start only.
  - char_frame >= CHAR_FRAMES is clamped to CHAR_FRAMES-1.
- Stage 0 (register addresses). Compute sx = DrawX>>1 and sy = DrawY>>1.
  - map_addr = menu_addr = sy*320 + sx, computed in 19 bits as (sy<<8)+(sy<<6)+sx. Maximum is 76799.
  - Sprite hit = pix_active and DrawX - char_x in [0,32) and DrawY - char_y in [0,32).
  - The subtractions are 11-bit signed. A negative result is a miss, so there is no wrap.
  - On a hit: char_addr = frame*256 + ((DrawY-char_y)>>1)*16 + ((DrawX-char_x)>>1). On a miss: char_addr = 0.
  - If pix_active = 0, or DrawX >= 640, or DrawY >= 480: all addresses are 0 and the stage valid bit is 0.
  - Valid, hit and mode travel down the pipeline alongside the addresses.
- Stage 1: wait one cycle for RAM data.
- Stage 2 (register output), using the stage-2 copy of mode:
  - Menu mode: pixel_index = menu_data.
  - Map mode: pixel_index = char_data if hit and char_data != TRANSPARENT, otherwise map_data.
  - pixel_valid = stage-2 valid. When valid is low, pixel_index = 0.

## Timing
- Latency: DrawX/DrawY at cycle t -> addresses registered at t+1 -> RAM data at t+2 -> pixel_index/pixel_valid at t+3.
- Throughput: one pixel per clock, with no stall or backpressure.
- Reset values: all addresses 0, pixel_index 0, pixel_valid 0, in_map 0, all pipeline valids 0, shadow registers 0, state MENU.
- Reset asserted mid-line: outputs are zero on the first Clk edge with Reset_n low. Pixels already in flight are dropped, not flushed.
- frame_start and start_press in the same cycle while in MENU: go to ARMED. MAP is entered on the following frame_start.
- frame_start during active pixels: the shadow registers update immediately. This is legal but not expected.
- A mode change takes effect only for pixels issued after the transition. In-flight pixels keep their captured mode.

## Structure
- Shared package pokemon_pkg:
  - MAP_W = 320, MAP_H = 240, SPR_DIM = 16, SCALE_SHIFT = 1.
  - typedef enum screen_state_t {MENU, ARMED, MAP}.
  - typedef struct fetch_stage_t {valid, hit, mode}.
- Natural sub-module: sprite_hit_calc, a combinational hit test plus char_addr computation, reused later for NPC sprites.
- The FSM and pipeline registers live in pixel_fetch_ctrl.

## Test plan
- Reset, then DrawX=0, DrawY=0, pix_active=1 -> map_addr=0 at t+1; pixel_valid=1 at t+3 with pixel_index = menu_data returned for address 0.
- DrawX=639, DrawY=479 -> map_addr=76799. Then DrawX=640 -> valid low at t+3 and pixel_index=0.
- start_press pulse mid-frame -> in_map stays 0 until the next frame_start, rises the cycle after it; menu pixels already in flight still output menu_data.
- In MAP with char_x=100, char_y=50, char_frame=3; DrawX=101, DrawY=53 -> char_addr = 768+16+0 = 784. With char_data=8'h00, output = map_data; with char_data=8'h2A, output = 8'h2A.
- char_x=630 and DrawX=5 -> miss, no wrap, char_addr=0. char_frame=31 -> clamped to 24, so the first sprite pixel address is 6144.
- Reset_n low for 1 cycle in MAP while streaming -> next cycle pixel_valid=0, in_map=0, all addresses 0.
